// File: rtl/delay_pkg.sv
// -----------------------------------------------------------------------------
// delay_pkg
// Shared constants for the multi-channel trigger delay block.
//   CNT_BITS_DEF   : default width of timestamp, delay and width counters
//   PEND_DEPTH_DEF : default number of in-flight triggers per channel
//   WIDTH_DEF      : pulse width loaded at reset
//   delay_max()    : largest legal delay for a given counter width
//                    (2^bits - 2), so that a due time can never equal the
//                    timestamp of the edge that queued it
//   DELAY_MAX_DEF  : delay_max() for the default counter width
// -----------------------------------------------------------------------------
package delay_pkg;

  localparam int CNT_BITS_DEF   = 32;
  localparam int PEND_DEPTH_DEF = 8;
  localparam int WIDTH_DEF      = 1;

  // Valid for bits up to 64; at 64 the shift wraps to 0 and the subtraction
  // still yields all-ones-minus-one.
  function automatic logic [63:0] delay_max(input int bits);
    return (64'd1 << bits) - 64'd2;
  endfunction

  localparam logic [CNT_BITS_DEF-1:0] DELAY_MAX_DEF =
    CNT_BITS_DEF'(delay_max(CNT_BITS_DEF));

endpackage

// File: rtl/delay_channel.sv
// -----------------------------------------------------------------------------
// delay_channel
// One delay channel: a FIFO of absolute due times, shadow/applied delay,
// pulse width register and width counter.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   ts           : free-running timestamp from the top level
//   trigger      : single-cycle trigger pulse
//   enable       : trigger acceptance gate
//   delay_data   : delay config value, written when delay_we is high
//   width_data   : width config value, written when width_we is high
//   ovf_clr      : clears the sticky overflow flag
//   pulse        : registered delayed output pulse
//   busy         : registered; queue non-empty or pulse active
//   overflow     : registered sticky flag; a trigger was dropped (queue full)
// -----------------------------------------------------------------------------
module delay_channel
  import delay_pkg::*;
#(
  parameter int CNT_BITS   = CNT_BITS_DEF,
  parameter int PEND_DEPTH = PEND_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CNT_BITS-1:0] ts,
  input  logic                trigger,
  input  logic                enable,
  input  logic [CNT_BITS-1:0] delay_data,
  input  logic                delay_we,
  input  logic [CNT_BITS-1:0] width_data,
  input  logic                width_we,
  input  logic                ovf_clr,
  output logic                pulse,
  output logic                busy,
  output logic                overflow
);

  localparam int PTR_W = $clog2(PEND_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_BITS-1:0] D_MAX    = CNT_BITS'(delay_max(CNT_BITS));
  localparam logic [CNT_BITS-1:0] ONE      = CNT_BITS'(1);
  localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(PEND_DEPTH);

  logic [CNT_BITS-1:0] due_mem [PEND_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_next;

  logic [CNT_BITS-1:0] shadow_delay;
  logic [CNT_BITS-1:0] applied_delay;
  logic [CNT_BITS-1:0] width;
  logic [CNT_BITS-1:0] remain;

  logic                q_empty;
  logic                q_full;
  logic                pop;
  logic                accept;
  logic                drop;
  logic [CNT_BITS-1:0] delay_sat;
  logic [CNT_BITS-1:0] shadow_next;
  logic [CNT_BITS-1:0] eff_delay;
  logic [CNT_BITS-1:0] due_push;
  logic [CNT_BITS-1:0] remain_next;
  logic                pulse_next;
  logic                overflow_next;

  // NOTE: every signal assigned in this block gets a value on every path
  // (defaults first), otherwise synthesis infers latches.
  always_comb begin
    q_empty     = (count == '0);
    q_full      = (count == FULL_CNT);
    pop         = !q_empty && (due_mem[rd_ptr] == ts);

    delay_sat   = (delay_data > D_MAX) ? D_MAX : delay_data;
    shadow_next = delay_we ? delay_sat : shadow_delay;
    // A new delay only takes effect while the queue is empty, so queued due
    // times stay monotonic and the head is always the next to expire. A write
    // landing on an empty queue is usable by a trigger on the same edge.
    eff_delay   = q_empty ? shadow_next : applied_delay;
    due_push    = ts + eff_delay + ONE;

    // A pop on the same edge frees a slot, so a full queue still accepts.
    accept      = trigger && enable && (!q_full || pop);
    drop        = trigger && enable && q_full && !pop;

    count_next  = count;
    if (accept && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (!accept && pop) begin
      count_next = count - CNT_W'(1);
    end

    // A pulse start reloads the counter even mid-pulse, so overlapping
    // pulses merge into one window without a gap.
    pulse_next  = 1'b0;
    remain_next = '0;
    if (pop) begin
      pulse_next  = 1'b1;
      remain_next = (width == '0) ? '0 : width - ONE;
    end else if (pulse && (remain != '0)) begin
      pulse_next  = 1'b1;
      remain_next = remain - ONE;
    end

    // Setting wins over a simultaneous clear.
    overflow_next = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      shadow_delay  <= '0;
      applied_delay <= '0;
      width         <= CNT_BITS'(WIDTH_DEF);
      remain        <= '0;
      pulse         <= 1'b0;
      busy          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count        <= count_next;
      shadow_delay <= shadow_next;
      if (q_empty) begin
        applied_delay <= shadow_next;
      end
      if (width_we) begin
        width <= width_data;
      end
      remain   <= remain_next;
      pulse    <= pulse_next;
      busy     <= (count_next != '0) || pulse_next;
      overflow <= overflow_next;
    end
  end

  // NOTE: the due-time storage has no reset; occupancy is tracked by count,
  // so stale entries are never compared.
  always_ff @(posedge clk) begin
    if (accept) begin
      due_mem[wr_ptr] <= due_push;
    end
  end

endmodule

// File: rtl/multi_channel_delay.sv
// -----------------------------------------------------------------------------
// multi_channel_delay
// NUM_CH independent trigger delay channels sharing one free-running
// timestamp. Each accepted trigger produces an output pulse D+1 edges later
// lasting W cycles; triggers are queued so overlapping requests all fire.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   trigger_in     : per-channel single-cycle trigger pulses (synchronous)
//   trigger_out    : per-channel delayed output pulses (registered)
//   cfg_ch         : channel addressed by a config write
//   cfg_delay      : delay value, written by cfg_delay_we
//   cfg_width      : pulse width value, written by cfg_width_we
//   ch_enable      : per-channel trigger acceptance mask
//   busy           : per-channel; triggers queued or pulse active
//   overflow       : per-channel sticky trigger-dropped flag
//   ovf_clr        : per-channel clear of overflow
// -----------------------------------------------------------------------------
module multi_channel_delay
  import delay_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int CNT_BITS   = CNT_BITS_DEF,
  parameter  int PEND_DEPTH = PEND_DEPTH_DEF,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   trigger_in,
  output logic [NUM_CH-1:0]   trigger_out,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_BITS-1:0] cfg_delay,
  input  logic [CNT_BITS-1:0] cfg_width,
  input  logic                cfg_delay_we,
  input  logic                cfg_width_we,
  input  logic [NUM_CH-1:0]   ch_enable,
  output logic [NUM_CH-1:0]   busy,
  output logic [NUM_CH-1:0]   overflow,
  input  logic [NUM_CH-1:0]   ovf_clr
);

  logic [CNT_BITS-1:0] ts;

  // Wraps modulo 2^CNT_BITS; due times are compared with equality only, which
  // is safe across the wrap because the delay is capped below 2^CNT_BITS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
    end else begin
      ts <= ts + CNT_BITS'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = (cfg_ch == CH_W'(i));

    delay_channel #(
      .CNT_BITS   (CNT_BITS),
      .PEND_DEPTH (PEND_DEPTH)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .ts         (ts),
      .trigger    (trigger_in[i]),
      .enable     (ch_enable[i]),
      .delay_data (cfg_delay),
      .delay_we   (cfg_delay_we && sel),
      .width_data (cfg_width),
      .width_we   (cfg_width_we && sel),
      .ovf_clr    (ovf_clr[i]),
      .pulse      (trigger_out[i]),
      .busy       (busy[i]),
      .overflow   (overflow[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_delay.sv
`timescale 1ns/1ps
module tb_multi_channel_delay;

  localparam int     NCH   = 4;
  localparam int     CB    = 32;
  localparam int     DEPTH = 8;
  localparam longint DMAX  = 64'd4294967294;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: default parameters.
  logic           rst_n = 1'b1;
  logic [NCH-1:0] trigger_in = '0, ch_enable = '0, ovf_clr = '0;
  logic [NCH-1:0] trigger_out, busy, overflow;
  logic [1:0]     cfg_ch = '0;
  logic [CB-1:0]  cfg_delay = '0, cfg_width = '0;
  logic           cfg_delay_we = 1'b0, cfg_width_we = 1'b0;

  // Small instance: 8-bit counters, exercises wrap and saturation.
  logic       s_rst_n = 1'b1;
  logic [1:0] s_trigger_in = '0, s_ch_enable = '0, s_ovf_clr = '0;
  logic [1:0] s_trigger_out, s_busy, s_overflow;
  logic       s_cfg_ch = 1'b0;
  logic [7:0] s_cfg_delay = '0, s_cfg_width = '0;
  logic       s_cfg_delay_we = 1'b0, s_cfg_width_we = 1'b0;

  multi_channel_delay dut (
    .clk(clk), .rst_n(rst_n), .trigger_in(trigger_in), .trigger_out(trigger_out),
    .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .cfg_width(cfg_width),
    .cfg_delay_we(cfg_delay_we), .cfg_width_we(cfg_width_we),
    .ch_enable(ch_enable), .busy(busy), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  multi_channel_delay #(.NUM_CH(2), .CNT_BITS(8), .PEND_DEPTH(4)) dut8 (
    .clk(clk), .rst_n(s_rst_n), .trigger_in(s_trigger_in), .trigger_out(s_trigger_out),
    .cfg_ch(s_cfg_ch), .cfg_delay(s_cfg_delay), .cfg_width(s_cfg_width),
    .cfg_delay_we(s_cfg_delay_we), .cfg_width_we(s_cfg_width_we),
    .ch_enable(s_ch_enable), .busy(s_busy), .overflow(s_overflow), .ovf_clr(s_ovf_clr)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model for the main instance. Time is an absolute edge index
  // (no wrap); each accepted trigger records the edge it is due. The output is
  // high whenever the most recent pulse start is less than its width ago.
  // ---------------------------------------------------------------------------
  longint   mq [NCH][$];
  longint   m_applied [NCH];
  longint   m_shadow [NCH];
  longint   m_width [NCH];
  longint   m_last_start [NCH];
  longint   m_last_w [NCH];
  bit       m_started [NCH];
  bit       m_ovf [NCH];
  longint   edge_n;
  logic [NCH-1:0] exp_out, exp_busy, exp_ovf;
  int       s_edge;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_applied[c] = 0; m_shadow[c] = 0; m_width[c] = 1;
      m_started[c] = 0; m_ovf[c] = 0; m_last_start[c] = 0; m_last_w[c] = 1;
    end
    edge_n = 0; exp_out = '0; exp_busy = '0; exp_ovf = '0;
  endtask

  task automatic model_step();
    int     sz;
    bit     pop;
    longint sh_n, eff, d_in;
    for (int c = 0; c < NCH; c++) begin
      sz   = mq[c].size();
      pop  = (sz != 0) && (mq[c][0] == edge_n);
      d_in = longint'(cfg_delay);
      sh_n = (cfg_delay_we && int'(cfg_ch) == c) ? ((d_in > DMAX) ? DMAX : d_in) : m_shadow[c];
      eff  = (sz == 0) ? sh_n : m_applied[c];
      if (sz == 0) m_applied[c] = sh_n;
      m_shadow[c] = sh_n;
      if (pop) begin
        void'(mq[c].pop_front());
        m_started[c] = 1; m_last_start[c] = edge_n;
        m_last_w[c] = (m_width[c] == 0) ? 1 : m_width[c];
      end
      if (cfg_width_we && int'(cfg_ch) == c) m_width[c] = longint'(cfg_width);
      if (trigger_in[c] && ch_enable[c] && sz == DEPTH && !pop) m_ovf[c] = 1;
      else begin
        if (trigger_in[c] && ch_enable[c]) mq[c].push_back(edge_n + eff + 1);
        if (ovf_clr[c]) m_ovf[c] = 0;
      end
      exp_out[c]  = m_started[c] && ((edge_n - m_last_start[c]) < m_last_w[c]);
      exp_busy[c] = (mq[c].size() != 0) || exp_out[c];
      exp_ovf[c]  = m_ovf[c];
    end
    edge_n++;
  endtask

  // One clock: model follows the edge, outputs are compared 1 ns later,
  // then single-cycle strobes are dropped.
  task automatic step();
    @(posedge clk);
    model_step();
    if (s_rst_n) s_edge++;
    #1;
    check("trigger_out", trigger_out, exp_out);
    check("busy", busy, exp_busy);
    check("overflow", overflow, exp_ovf);
    trigger_in = '0; cfg_delay_we = 1'b0; cfg_width_we = 1'b0; ovf_clr = '0;
    s_trigger_in = '0; s_cfg_delay_we = 1'b0; s_cfg_width_we = 1'b0; s_ovf_clr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    trigger_in = '0; ch_enable = '0; ovf_clr = '0; cfg_delay_we = 1'b0; cfg_width_we = 1'b0;
    model_reset();
    #1;
    check("rst trigger_out", trigger_out, 0);
    check("rst busy", busy, 0);
    check("rst overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cfg(input int ch, input int d, input int w);
    cfg_ch = 2'(ch); cfg_delay = CB'(d); cfg_width = CB'(w);
    cfg_delay_we = 1'b1; cfg_width_we = 1'b1;
    step();
  endtask

  // Runs n cycles on one channel; triggers where trig has a 1, optional delay
  // write and enable drop at given offsets. Records where the output was high.
  task automatic run_seq(input int ch, input logic [63:0] trig, input int n,
                         input int dw_at, input int dw_val, input int en_off_at,
                         output logic [63:0] seen, output int highs);
    seen = '0; highs = 0;
    for (int j = 0; j < n; j++) begin
      if (j < 64 && trig[j]) trigger_in[ch] = 1'b1;
      if (j == dw_at) begin cfg_ch = 2'(ch); cfg_delay = CB'(dw_val); cfg_delay_we = 1'b1; end
      if (j == en_off_at) ch_enable[ch] = 1'b0;
      step();
      if (trigger_out[ch]) begin
        if (j < 64) seen[j] = 1'b1;
        highs++;
      end
    end
  endtask

  typedef struct {
    int d;
    int w;
    bit same_edge;
    int exp_first;
    int exp_len;
  } vec_t;

  vec_t           vt [6];
  logic [63:0]    seen;
  int             highs, first, rate;

  initial begin
    vt[0] = '{5, 3, 1'b0, 6, 3};
    vt[1] = '{0, 1, 1'b0, 1, 1};
    vt[2] = '{0, 0, 1'b0, 1, 1};
    vt[3] = '{4, 2, 1'b1, 5, 2};
    vt[4] = '{9, 6, 1'b0, 10, 6};
    vt[5] = '{1, 0, 1'b0, 2, 1};

    // Power-on reset of both instances.
    #2;
    rst_n = 1'b0; s_rst_n = 1'b0;
    model_reset();
    #1;
    check("por trigger_out", trigger_out, 0);
    check("por busy", busy, 0);
    check("por overflow", overflow, 0);
    check("por s trigger_out", s_trigger_out, 0);
    check("por s busy", s_busy, 0);
    check("por s overflow", s_overflow, 0);
    @(negedge clk);
    rst_n = 1'b1; s_rst_n = 1'b1; s_edge = 0;

    // 8-bit wrap: trigger at ts=250 with D=10, W=3 -> first high at ts=5.
    s_cfg_ch = 1'b0; s_cfg_delay = 8'd10; s_cfg_width = 8'd3;
    s_cfg_delay_we = 1'b1; s_cfg_width_we = 1'b1; s_ch_enable = 2'b01;
    step();
    first = -1;
    for (int g = 0; g < 400 && s_edge < 262; g++) begin
      if (s_edge == 250 || s_edge == 255) s_trigger_in[0] = 1'b1;
      step();
      if (s_trigger_out[0] && first < 0) first = (s_edge - 1) % 256;
    end
    check("wrap first ts", first, 5);
    check("wrap high", s_trigger_out[0], 1);
    // Reset mid-pulse with a second trigger still queued.
    #1; s_rst_n = 1'b0;
    #1;
    check("mid-pulse rst out", s_trigger_out, 0);
    check("mid-pulse rst busy", s_busy, 0);
    step();
    @(negedge clk); s_rst_n = 1'b1; s_edge = 0;
    highs = 0;
    for (int j = 0; j < 40; j++) begin step(); if (s_trigger_out != 0) highs++; end
    check("post-rst highs", highs, 0);

    // 8-bit saturation: D=255 is clamped to 254 -> first high 255 edges later.
    s_cfg_ch = 1'b1; s_cfg_delay = 8'd255; s_cfg_width = 8'd1;
    s_cfg_delay_we = 1'b1; s_cfg_width_we = 1'b1; s_ch_enable = 2'b10;
    step();
    s_trigger_in[1] = 1'b1;
    step();
    first = -1; highs = 0;
    for (int j = 1; j < 300; j++) begin
      step();
      if (s_trigger_out[1]) begin if (first < 0) first = j; highs++; end
    end
    check("sat first", first, 255);
    check("sat len", highs, 1);

    // Table: single trigger latency and pulse length on channel 0.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      ch_enable = 4'b0001;
      if (vt[i].same_edge) begin
        cfg_ch = 2'd0; cfg_delay = CB'(vt[i].d); cfg_width = CB'(vt[i].w);
        cfg_delay_we = 1'b1; cfg_width_we = 1'b1; trigger_in[0] = 1'b1;
        step();
      end else begin
        cfg(0, vt[i].d, vt[i].w);
        trigger_in[0] = 1'b1;
        step();
      end
      first = -1; highs = 0;
      for (int j = 1; j <= 40; j++) begin
        step();
        if (trigger_out[0]) begin if (first < 0) first = j; highs++; end
      end
      check($sformatf("vec%0d first", i), first, vt[i].exp_first);
      check($sformatf("vec%0d len", i), highs, vt[i].exp_len);
    end

    // Overlapping triggers, D=20 W=1 at 0,3,7.
    do_reset(); cfg(0, 20, 1); ch_enable = 4'b0001;
    run_seq(0, (64'd1 << 0) | (64'd1 << 3) | (64'd1 << 7), 40, -1, 0, -1, seen, highs);
    check("overlap pulses", seen, (64'd1 << 21) | (64'd1 << 24) | (64'd1 << 28));

    // Retrigger merge: W=4, pulses due 2 apart -> 6-cycle window.
    do_reset(); cfg(0, 3, 4); ch_enable = 4'b0001;
    run_seq(0, (64'd1 << 0) | (64'd1 << 2), 20, -1, 0, -1, seen, highs);
    check("merge window", seen, 64'h3F0);
    check("merge len", highs, 6);

    // Delay change with queued triggers on channel 3.
    do_reset(); cfg(3, 10, 1); ch_enable = 4'b1000;
    run_seq(3, (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 3) | (64'd1 << 20), 30, 2, 2, -1, seen, highs);
    check("shadow delay", seen, (64'd1 << 11) | (64'd1 << 12) | (64'd1 << 14) | (64'd1 << 23));

    // Disabling a channel ignores new triggers but keeps queued ones.
    do_reset(); cfg(3, 5, 1); ch_enable = 4'b1000;
    run_seq(3, (64'd1 << 0) | (64'd1 << 2), 20, -1, 0, 1, seen, highs);
    check("enable mask", seen, 64'd1 << 6);

    // Full queue with simultaneous pop accepts: D=7, 9 back-to-back triggers.
    do_reset(); cfg(2, 7, 1); ch_enable = 4'b0100;
    run_seq(2, 64'h1FF, 30, -1, 0, -1, seen, highs);
    check("full+pop highs", highs, 9);
    check("full+pop ovf", overflow[2], 0);

    // Overflow: D=100, 9 triggers -> 8 kept, sticky flag, set beats clear.
    do_reset(); cfg(1, 100, 1); ch_enable = 4'b0010;
    for (int j = 0; j < 9; j++) begin trigger_in[1] = 1'b1; step(); end
    check("ovf set", overflow[1], 1);
    trigger_in[1] = 1'b1; ovf_clr[1] = 1'b1; step();
    check("ovf set vs clr", overflow[1], 1);
    highs = 0;
    for (int j = 0; j < 110; j++) begin step(); if (trigger_out[1]) highs++; end
    check("ovf pulses", highs, 8);
    ovf_clr[1] = 1'b1; step();
    check("ovf cleared", overflow[1], 0);
    check("ovf idle busy", busy[1], 0);

    // Randomized traffic against the model, then a reset with work in flight.
    do_reset();
    ch_enable = NCH'($urandom);
    for (int i = 0; i < 2600; i++) begin
      rate = (i < 1200) ? 40 : 12;
      for (int c = 0; c < NCH; c++) begin
        trigger_in[c] = ($urandom_range(0, 99) < rate);
        ovf_clr[c]    = ($urandom_range(0, 39) == 0);
      end
      if ($urandom_range(0, 49) == 0) ch_enable = NCH'($urandom);
      cfg_ch = 2'($urandom);
      if ($urandom_range(0, 14) == 0) begin
        cfg_delay = CB'($urandom_range(0, 40)); cfg_delay_we = 1'b1;
      end
      if ($urandom_range(0, 14) == 0) begin
        cfg_width = CB'($urandom_range(0, 6)); cfg_width_we = 1'b1;
      end
      step();
    end
    do_reset();
    for (int j = 0; j < 60; j++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
